// File: rtl/control_pkg.sv
// Shared encodings for the RV32I control unit: opcodes, immediate formats,
// internal ALU-op classes, ALU operation selects and the main-decode payload.
// Optional feature macro used by this slice: CONTROL_BNE_EN (BNE support).
package control_pkg;

    localparam int unsigned OPCODE_W   = 7;
    localparam int unsigned FUNC3_W    = 3;
    localparam int unsigned FUNC7_W    = 7;
    localparam int unsigned IMM_TYPE_W = 3;
    localparam int unsigned ALU_OP_W   = 2;
    localparam int unsigned ALU_CTRL_W = 3;

    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    localparam logic [FUNC3_W-1:0] F3_BEQ = 3'b000;
    localparam logic [FUNC3_W-1:0] F3_BNE = 3'b001;

    typedef enum logic [IMM_TYPE_W-1:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010
    } imm_type_e;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_OP_ADD  = 2'b00,
        ALU_OP_SUB  = 2'b01,
        ALU_OP_FUNC = 2'b10
    } alu_op_e;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_ctrl_e;

    // Main-decoder payload handed to the datapath controls.
    typedef struct packed {
        imm_type_e imm_type;
        logic      mem_write;
        logic      reg_write;
        logic      alu_source;
        logic      result_source;
        alu_op_e   alu_op;
    } main_dec_s;

    // Safe all-zero decode used for unknown opcodes.
    function automatic main_dec_s main_dec_idle();
        main_dec_s d;
        d.imm_type      = IMM_I;
        d.mem_write     = 1'b0;
        d.reg_write     = 1'b0;
        d.alu_source    = 1'b0;
        d.result_source = 1'b0;
        d.alu_op        = ALU_OP_ADD;
        return d;
    endfunction

endpackage

// File: rtl/control_unit_alu_decoder.sv
// ALU decoder: turns the main decoder's alu_op class plus func fields into an
// ALU operation select, flagging the reserved func3 = 011 slot as illegal.
module alu_decoder
    import control_pkg::*;
(
    input  alu_op_e                 i_alu_op,
    input  logic [FUNC3_W-1:0]      i_func3,
    input  logic                    i_func7_5,
    input  logic                    i_op_code_5,
    output logic [ALU_CTRL_W-1:0]   o_alu_control,
    output logic                    o_func_illegal
);

    alu_ctrl_e w_alu_control;
    logic      w_func_illegal;

    // Select the ALU operation; SRA/SRAI collapse onto SRL.
    always_comb begin
        w_alu_control  = ALU_ADD;
        w_func_illegal = 1'b0;
        case (i_alu_op)
            ALU_OP_ADD: w_alu_control = ALU_ADD;
            ALU_OP_SUB: w_alu_control = ALU_SUB;
            ALU_OP_FUNC: begin
                case (i_func3)
                    3'b000: begin
                        // op_code[5] separates R-type from I-type, so ADDI never subtracts.
                        if (i_op_code_5 && i_func7_5) begin
                            w_alu_control = ALU_SUB;
                        end else begin
                            w_alu_control = ALU_ADD;
                        end
                    end
                    3'b111:  w_alu_control = ALU_AND;
                    3'b110:  w_alu_control = ALU_OR;
                    3'b100:  w_alu_control = ALU_XOR;
                    3'b010:  w_alu_control = ALU_SLT;
                    3'b001:  w_alu_control = ALU_SLL;
                    3'b101:  w_alu_control = ALU_SRL;
                    default: begin
                        w_alu_control  = ALU_ADD;
                        w_func_illegal = 1'b1;
                    end
                endcase
            end
            default: w_alu_control = ALU_ADD;
        endcase
    end

    assign o_alu_control  = w_alu_control;
    assign o_func_illegal = w_func_illegal;

endmodule

// File: rtl/control_unit.sv
// RV32I control unit: combinational main decoder, branch resolution and a
// sticky illegal-instruction flag; ALU operation decode lives in alu_decoder.
// Optional macro CONTROL_BNE_EN: treat branch func3 001 (BNE) as legal.
module control_unit
    import control_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_W-1:0]     op_code,
    input  logic                    zero,
    input  logic [FUNC3_W-1:0]      func3,
    input  logic [FUNC7_W-1:0]      func7,
    output logic                    mem_write,
    output logic                    reg_write,
    output logic                    alu_source,
    output logic                    result_source,
    output logic [IMM_TYPE_W-1:0]   imm_type,
    output logic [ALU_CTRL_W-1:0]   alu_control,
    output logic                    pc_source,
    output logic                    illegal_op
);

    main_dec_s w_dec;
    logic      w_op_illegal;
    logic      w_func_illegal;
    logic      w_branch_illegal;
    logic      w_pc_source;
    logic      w_illegal;
    logic      r_illegal_op;
    logic      w_unused_func7;

    // Only func7[5] carries meaning for the supported subset.
    assign w_unused_func7 = ^{func7[6], func7[4:0]};

    // Main decode by opcode; unknown opcodes fall back to an all-zero decode.
    always_comb begin
        w_dec        = main_dec_idle();
        w_op_illegal = 1'b0;
        case (op_code)
            OP_LOAD: begin
                w_dec.imm_type      = IMM_I;
                w_dec.reg_write     = 1'b1;
                w_dec.alu_source    = 1'b1;
                w_dec.result_source = 1'b1;
                w_dec.alu_op        = ALU_OP_ADD;
            end
            OP_STORE: begin
                w_dec.imm_type      = IMM_S;
                w_dec.mem_write     = 1'b1;
                w_dec.alu_source    = 1'b1;
                w_dec.alu_op        = ALU_OP_ADD;
            end
            OP_RTYPE: begin
                w_dec.imm_type      = IMM_I;
                w_dec.reg_write     = 1'b1;
                w_dec.alu_op        = ALU_OP_FUNC;
            end
            OP_ITYPE: begin
                w_dec.imm_type      = IMM_I;
                w_dec.reg_write     = 1'b1;
                w_dec.alu_source    = 1'b1;
                w_dec.alu_op        = ALU_OP_FUNC;
            end
            OP_BRANCH: begin
                w_dec.imm_type      = IMM_B;
                w_dec.alu_op        = ALU_OP_SUB;
            end
            default: begin
                w_dec        = main_dec_idle();
                w_op_illegal = 1'b1;
            end
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op       (w_dec.alu_op),
        .i_func3        (func3),
        .i_func7_5      (func7[5]),
        .i_op_code_5    (op_code[5]),
        .o_alu_control  (alu_control),
        .o_func_illegal (w_func_illegal)
    );

    // Branch resolution from the ALU zero flag; unsupported conditions never branch.
    always_comb begin
        w_pc_source      = 1'b0;
        w_branch_illegal = 1'b0;
        if (op_code == OP_BRANCH) begin
            case (func3)
                F3_BEQ: w_pc_source = zero;
`ifdef CONTROL_BNE_EN
                F3_BNE: w_pc_source = ~zero;
`endif
                default: begin
                    w_pc_source      = 1'b0;
                    w_branch_illegal = 1'b1;
                end
            endcase
        end
    end

    assign w_illegal = w_op_illegal | w_func_illegal | w_branch_illegal;

    // Sticky illegal-instruction flag; reset wins over a same-edge illegal decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_op <= 1'b0;
        end else if (w_illegal) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign mem_write     = w_dec.mem_write;
    assign reg_write     = w_dec.reg_write;
    assign alu_source    = w_dec.alu_source;
    assign result_source = w_dec.result_source;
    assign imm_type      = w_dec.imm_type;
    assign pc_source     = w_pc_source;
    assign illegal_op    = r_illegal_op;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: decode vectors with hand-computed outputs,
// then the sticky illegal flag and its reset behaviour.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [6:0] op_code;
    logic       zero;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       mem_write;
    logic       reg_write;
    logic       alu_source;
    logic       result_source;
    logic [2:0] imm_type;
    logic [2:0] alu_control;
    logic       pc_source;
    logic       illegal_op;

    int checks;
    int errors;

    // Packed view: {imm_type, mem_write, reg_write, alu_source, result_source, alu_control, pc_source}
    logic [10:0] w_outs;
    assign w_outs = {imm_type, mem_write, reg_write, alu_source, result_source, alu_control, pc_source};

    control_unit dut (
        .clk           (clk),
        .rst           (rst),
        .op_code       (op_code),
        .zero          (zero),
        .func3         (func3),
        .func7         (func7),
        .mem_write     (mem_write),
        .reg_write     (reg_write),
        .alu_source    (alu_source),
        .result_source (result_source),
        .imm_type      (imm_type),
        .alu_control   (alu_control),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7, input logic z);
        @(negedge clk);
        op_code = op;
        func3   = f3;
        func7   = f7;
        zero    = z;
        #1;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        z;
        logic [10:0] exp;
    } vec_t;

`ifdef CONTROL_BNE_EN
    localparam logic       BNE_Z0_PC = 1'b1;
    localparam logic       BNE_ILL   = 1'b0;
`else
    localparam logic       BNE_Z0_PC = 1'b0;
    localparam logic       BNE_ILL   = 1'b1;
`endif

    // Legal decodes only; expected = {imm,mw,rw,as,rs,alu,pc}.
    vec_t legal_vecs[] = '{
        '{7'b0000011, 3'b010, 7'h00, 1'b0, {3'b000, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000, 1'b0}}, // LW
        '{7'b0100011, 3'b010, 7'h00, 1'b0, {3'b001, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0}}, // SW
        '{7'b0110011, 3'b000, 7'h00, 1'b0, {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0}}, // ADD
        '{7'b0110011, 3'b000, 7'h20, 1'b0, {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0}}, // SUB
        '{7'b0010011, 3'b000, 7'h20, 1'b0, {3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0}}, // ADDI, no SUB
        '{7'b0010011, 3'b111, 7'h00, 1'b0, {3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0}}, // ANDI
        '{7'b0010011, 3'b110, 7'h00, 1'b0, {3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b011, 1'b0}}, // ORI
        '{7'b0010011, 3'b101, 7'h20, 1'b0, {3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0}}, // SRAI->SRL
        '{7'b0110011, 3'b100, 7'h00, 1'b0, {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b100, 1'b0}}, // XOR
        '{7'b0110011, 3'b010, 7'h00, 1'b0, {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 1'b0}}, // SLT
        '{7'b0110011, 3'b001, 7'h00, 1'b0, {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 1'b0}}, // SLL
        '{7'b0110011, 3'b101, 7'h20, 1'b0, {3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b111, 1'b0}}, // SRA->SRL
        '{7'b1100011, 3'b000, 7'h00, 1'b1, {3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1}}, // BEQ taken
        '{7'b1100011, 3'b000, 7'h00, 1'b0, {3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0}}  // BEQ not taken
    };

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        op_code = 7'b0000011;
        func3   = 3'b000;
        func7   = 7'h00;
        zero    = 1'b0;

        // Reset state of the sticky flag.
        edge_settle();
        check("reset_illegal", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (legal_vecs[i]) begin
            drive(legal_vecs[i].op, legal_vecs[i].f3, legal_vecs[i].f7, legal_vecs[i].z);
            check($sformatf("dec%0d", i), 32'(w_outs), 32'(legal_vecs[i].exp));
        end
        edge_settle();
        check("legal_no_illegal", 32'(illegal_op), 32'd0);

        // BNE: outcome and legality depend on the build option.
        drive(7'b1100011, 3'b001, 7'h00, 1'b0);
        check("bne_z0", 32'(w_outs), 32'({3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, BNE_Z0_PC}));
        drive(7'b1100011, 3'b001, 7'h00, 1'b1);
        check("bne_z1", 32'(w_outs), 32'({3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0}));
        edge_settle();
        check("bne_sticky", 32'(illegal_op), 32'(BNE_ILL));

        @(negedge clk);
        rst = 1'b1;
        op_code = 7'b0000011;
        edge_settle();
        check("rst_clear0", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unsupported branch condition (BLT) never branches and is illegal.
        drive(7'b1100011, 3'b100, 7'h00, 1'b1);
        check("blt_dec", 32'(w_outs), 32'({3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0}));
        edge_settle();
        check("blt_sticky", 32'(illegal_op), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        op_code = 7'b0000011;
        edge_settle();
        check("rst_clear1", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reserved func3 = 011 under I-type.
        drive(7'b0010011, 3'b011, 7'h00, 1'b0);
        check("itype_f3_011", 32'(w_outs), 32'({3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0}));
        edge_settle();
        check("f3_011_sticky", 32'(illegal_op), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        edge_settle();
        check("rst_clear2", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unknown opcode: all-zero decode, sticky set, held afterwards.
        drive(7'b1111111, 3'b000, 7'h20, 1'b1);
        check("unknown_op_dec", 32'(w_outs), 32'd0);
        edge_settle();
        check("unknown_sticky", 32'(illegal_op), 32'd1);
        drive(7'b0000011, 3'b000, 7'h00, 1'b0);
        edge_settle();
        edge_settle();
        check("sticky_hold", 32'(illegal_op), 32'd1);

        // One reset edge clears.
        @(negedge clk);
        rst = 1'b1;
        edge_settle();
        check("rst_clear3", 32'(illegal_op), 32'd0);

        // Reset beats a simultaneous illegal decode.
        @(negedge clk);
        op_code = 7'b1111111;
        edge_settle();
        check("rst_priority", 32'(illegal_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op_code = 7'b0000011;
        edge_settle();
        check("after_rst_legal", 32'(illegal_op), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
